// File: rtl/sm4_pkg.sv
// Shared SM4 constants and primitives: S-box table, bytewise substitution,
// the round linear transform and the engine FSM encoding.
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sm4_eng_state_e;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] sm4_sbox32(input logic [31:0] a);
        return {SM4_SBOX[a[31:24]], SM4_SBOX[a[23:16]], SM4_SBOX[a[15:8]], SM4_SBOX[a[7:0]]};
    endfunction

    // B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24)
    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

endpackage

// File: rtl/sm4_round_unit.sv
// One combinational SM4 round: shifts the four-word window and appends
// X0 ^ T(X1 ^ X2 ^ X3 ^ rk).
module sm4_round_unit
    import sm4_pkg::*;
(
    input  logic [127:0] x,
    input  logic [31:0]  rk,
    output logic [127:0] y
);

    logic [31:0] x0, x1, x2, x3, t;

    assign {x0, x1, x2, x3} = x;
    assign t = sm4_l(sm4_sbox32(x1 ^ x2 ^ x3 ^ rk));
    assign y = {x1, x2, x3, x0 ^ t};

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 datapath: ROUNDS_PER_CYCLE chained rounds per clock, shared
// by encrypt and decrypt, with valid/ready handshakes on both sides.
module sm4_round_engine
    import sm4_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          mode_i,
    input  logic [127:0]  data_i,
    input  logic [1023:0] rk_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [127:0]  data_o,
    output logic          busy_o
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_param
        $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] STEP = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST = 6'(SM4_ROUNDS);

    sm4_eng_state_e state;
    logic [5:0]     cnt;
    logic           mode;
    logic [127:0]   x;

    logic [31:0]    rk_arr [SM4_ROUNDS];
    logic [127:0]   chain  [ROUNDS_PER_CYCLE+1];

    for (genvar i = 0; i < SM4_ROUNDS; i++) begin : g_rk
        assign rk_arr[i] = rk_i[1023-32*i -: 32];
    end

    assign chain[0] = x;

    // Decrypt walks the same schedule backwards; the index wraps harmlessly
    // once cnt sits at 32 because the chain output is then ignored.
    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [4:0] ridx;
        logic [4:0] kidx;
        assign ridx = cnt[4:0] + 5'(k);
        assign kidx = mode ? (5'd31 - ridx) : ridx;
        sm4_round_unit u_round (
            .x  (chain[k]),
            .rk (rk_arr[kidx]),
            .y  (chain[k+1])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            mode        <= 1'b0;
            x           <= '0;
            data_o      <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        x          <= data_i;
                        mode       <= mode_i;
                        cnt        <= '0;
                        state      <= BUSY;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        // Final reverse transform R: word order flipped.
                        data_o      <= {x[31:0], x[63:32], x[95:64], x[127:96]};
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        x   <= chain[ROUNDS_PER_CYCLE];
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
